conv_encoder: RTL and testbench



---
 rtl/viterbi_pkg.sv | 35 +++
 rtl/conv_encoder_if.sv | 34 +++
 rtl/conv_encoder_parity.sv | 18 +
 rtl/conv_encoder.sv | 100 ++++++++++
 tb/tb_conv_encoder.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/viterbi_pkg.sv
// Shared encoder/decoder definitions: code geometry,
// generator polynomials and the parity helper.
package viterbi_pkg;

  localparam int r      = 2;
  localparam int K      = 3;
  localparam int lenout = 5;
  localparam int lenin  = 10;

  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  localparam int ST_W  = (1 << (K-1)) * 2 * r;
  localparam int CNT_W = $clog2(lenout + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } enc_state_e;

  function automatic logic parity(
    input logic [K-1:0] win,
    input logic [K-1:0] g
  );
    return ^(win & g);
  endfunction

  function automatic logic [K-1:0] gen_poly(
    input int j
  );
    return (j == 0) ? G0 : G1;
  endfunction

endpackage

// File: rtl/conv_encoder_if.sv
// Message-in / code-word-out bundle between the
// encoder and its producer/consumer.
interface conv_encoder_if;
  import viterbi_pkg::*;

  logic [lenout-1:0] msg_in;
  logic              msg_valid;
  logic              msg_ready;
  logic [lenin-1:0]  err_mask;
  logic [lenin-1:0]  codein;
  logic              code_valid;
  logic [ST_W-1:0]   states;

  modport master (
    output msg_in,
    output msg_valid,
    output err_mask,
    input  msg_ready,
    input  codein,
    input  code_valid,
    input  states
  );

  modport slave (
    input  msg_in,
    input  msg_valid,
    input  err_mask,
    output msg_ready,
    output codein,
    output code_valid,
    output states
  );

endinterface

// File: rtl/conv_encoder_parity.sv
// Window {b,s} to r parity bits, p0 in the MSB.
// Shared by the datapath and the table generator.
module conv_parity
  import viterbi_pkg::*;
(
  input  logic [K-1:0] win_i,
  output logic [r-1:0] par_o
);

  // one parity bit per generator polynomial
  always_comb begin
    par_o = '0;
    for (int j = 0; j < r; j++) begin
      par_o[r-1-j] = parity(win_i, gen_poly(j));
    end
  end

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/r convolutional encoder feeding the Viterbi
// decoder, with expected-parity table and error mask.
module conv_encoder
  import viterbi_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  conv_encoder_if.slave enc
);

  if (lenin != r * lenout) begin : g_chk
    $fatal(1, "conv_encoder: lenin must equal r*lenout");
  end

  enc_state_e        state_q, state_d;
  logic [lenout-1:0] msg_q, msg_d;
  logic [K-2:0]      sreg_q, sreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [lenin-1:0]  acc_q, acc_d;
  logic [lenin-1:0]  codein_q, codein_d;

  logic              bit_w;
  logic [r-1:0]      sym_w;
  logic              hs_w;
  logic [ST_W-1:0]   states_w;

  assign bit_w = msg_q[lenout-1];
  assign hs_w  = enc.msg_valid && enc.msg_ready;

  conv_parity u_dp (
    .win_i ({bit_w, sreg_q}),
    .par_o (sym_w)
  );

  for (genvar e = 0; e < (1 << K); e++) begin : g_tab
    localparam logic [K-1:0] EW = K'(e);
    conv_parity u_tab (
      .win_i ({EW[0], EW[K-1:1]}),
      .par_o (states_w[e*r +: r])
    );
  end

  assign enc.states     = states_w;
  assign enc.msg_ready  = (state_q != SHIFT);
  assign enc.code_valid = (state_q == DONE);
  assign enc.codein     = codein_q;

  // accept, shift one bit per cycle, then register the word
  always_comb begin
    state_d  = state_q;
    msg_d    = msg_q;
    sreg_d   = sreg_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    codein_d = codein_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (hs_w) begin
          state_d = SHIFT;
          msg_d   = enc.msg_in;
          sreg_d  = '0;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_W'(lenout)) begin
          state_d  = DONE;
          codein_d = acc_q ^ enc.err_mask;
        end else begin
          msg_d  = msg_q << 1;
          sreg_d = {bit_w, sreg_q[K-2:1]};
          cnt_d  = cnt_q + 1'b1;
          acc_d  = {acc_q[lenin-r-1:0], sym_w};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      msg_q    <= '0;
      sreg_q   <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      codein_q <= '0;
    end else begin
      state_q  <= state_d;
      msg_q    <= msg_d;
      sreg_q   <= sreg_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      codein_q <= codein_d;
    end
  end

endmodule

// File: tb/tb_conv_encoder.sv
// Scoreboard bench for conv_encoder: reset, encode,
// back-to-back, ignored pulse and mid-shift reset.
module tb_conv_encoder;
  import viterbi_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  conv_encoder_if bus ();

  conv_encoder dut (
    .clk (clk),
    .rst (rst),
    .enc (bus)
  );

  int errs   = 0;
  int checks = 0;
  logic [lenin-1:0] sb[$];

  function automatic logic [9:0] model(input logic [4:0] m);
    logic s1, s0, b;
    logic [9:0] c;
    s1 = 1'b0;
    s0 = 1'b0;
    c  = '0;
    for (int i = 4; i >= 0; i--) begin
      b  = m[i];
      c  = {c[7:0], b ^ s1 ^ s0, b ^ s0};
      s0 = s1;
      s1 = b;
    end
    return c;
  endfunction

  task automatic offer(input logic [4:0] m,
                       input logic [9:0] mask,
                       input logic [9:0] exp);
    @(negedge clk);
    bus.msg_in    = m;
    bus.err_mask  = mask;
    bus.msg_valid = 1'b1;
    checks++;
    if (bus.msg_ready !== 1'b1) begin
      errs++;
      $display("FAIL offer_ready: got %b want 1", bus.msg_ready);
    end
    @(posedge clk);
    #1;
    bus.msg_valid = 1'b0;
    sb.push_back(exp);
  endtask

  task automatic collect(input int start, input string nm);
    int lat;
    logic [9:0] exp;
    lat = start;
    while (bus.code_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat != 6) begin
      errs++;
      $display("FAIL %s_latency: got %0d want 6", nm, lat);
    end
    checks++;
    if (sb.size() == 0) begin
      errs++;
      $display("FAIL %s_sb: got empty want entry", nm);
    end else begin
      exp = sb.pop_front();
      checks++;
      if (bus.codein !== exp) begin
        errs++;
        $display("FAIL %s_code: got %h want %h",
                 nm, bus.codein, exp);
      end
    end
  endtask

  task automatic check_idle_outputs(input string nm);
    checks++;
    if (bus.msg_ready !== 1'b1) begin
      errs++;
      $display("FAIL %s_ready: got %b want 1", nm, bus.msg_ready);
    end
    checks++;
    if (bus.code_valid !== 1'b0) begin
      errs++;
      $display("FAIL %s_valid: got %b want 0", nm, bus.code_valid);
    end
    checks++;
    if (bus.codein !== 10'h000) begin
      errs++;
      $display("FAIL %s_codein: got %h want 000", nm, bus.codein);
    end
    checks++;
    if (bus.states !== 16'h963C) begin
      errs++;
      $display("FAIL %s_states: got %h want 963c", nm, bus.states);
    end
  endtask

  task automatic test_reset();
    rst           = 1'b0;
    bus.msg_valid = 1'b0;
    bus.msg_in    = '0;
    bus.err_mask  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_encode();
    logic [4:0] msgs [4];
    logic [9:0] masks[4];
    logic [9:0] exps [4];
    logic [4:0] m;
    logic [9:0] k;
    msgs[0] = 5'b10110; masks[0] = 10'h000; exps[0] = 10'h385;
    msgs[1] = 5'b11111; masks[1] = 10'h000; exps[1] = 10'h36A;
    msgs[2] = 5'b00000; masks[2] = 10'h000; exps[2] = 10'h000;
    msgs[3] = 5'b10110; masks[3] = 10'h004; exps[3] = 10'h381;
    for (int i = 0; i < 4; i++) begin
      offer(msgs[i], masks[i], exps[i]);
      collect(0, "encode");
    end
    @(negedge clk);
    bus.err_mask = 10'h3FF;
    @(posedge clk);
    #1;
    checks++;
    if (bus.codein !== 10'h381 || bus.code_valid !== 1'b1) begin
      errs++;
      $display("FAIL mask_hold: got %h/%b want 381/1",
               bus.codein, bus.code_valid);
    end
    for (int i = 0; i < 3; i++) begin
      m = 5'($urandom_range(0, 31));
      k = 10'($urandom_range(0, 1023));
      offer(m, k, model(m) ^ k);
      collect(0, "random");
    end
  endtask

  task automatic test_back_to_back();
    offer(5'b10110, 10'h000, 10'h385);
    collect(0, "b2b_first");
    offer(5'b11111, 10'h000, 10'h36A);
    checks++;
    if (bus.code_valid !== 1'b0) begin
      errs++;
      $display("FAIL b2b_drop: got %b want 0", bus.code_valid);
    end
    @(negedge clk);
    bus.msg_in    = 5'b00001;
    bus.msg_valid = 1'b1;
    checks++;
    if (bus.msg_ready !== 1'b0) begin
      errs++;
      $display("FAIL shift_ready: got %b want 0", bus.msg_ready);
    end
    @(posedge clk);
    #1;
    bus.msg_valid = 1'b0;
    collect(1, "b2b_second");
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (bus.code_valid !== 1'b1 || bus.codein !== 10'h36A) begin
      errs++;
      $display("FAIL pulse_ignored: got %h/%b want 36a/1",
               bus.codein, bus.code_valid);
    end
    checks++;
    if (sb.size() != 0) begin
      errs++;
      $display("FAIL sb_drain: got %0d want 0", sb.size());
    end
  endtask

  task automatic test_reset_mid_shift();
    offer(5'b11111, 10'h000, 10'h36A);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle_outputs("midrst");
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    offer(5'b10110, 10'h000, 10'h385);
    collect(0, "after_rst");
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_encode();
    test_back_to_back();
    test_reset_mid_shift();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
